// File: rtl/jump_target_table.sv
// Maps a jump pointer to a full PC target. Entries are loaded at run time and can be
// absolute or PC-relative. A sweep FSM invalidates the table after reset or on Clear.
module jump_target_table #(
  parameter int unsigned PC_W        = 10,
  parameter int unsigned IDX_W       = 5,
  parameter int unsigned DEFAULT_TGT = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clear,
  input  logic             LoadValid,
  output logic             LoadReady,
  input  logic [IDX_W-1:0] LoadIdx,
  input  logic [PC_W-1:0]  LoadTarget,
  input  logic             LoadRel,
  input  logic             LookupEn,
  input  logic [IDX_W-1:0] Addr,
  input  logic [PC_W-1:0]  PC,
  output logic [PC_W-1:0]  Target,
  output logic             TargetValid,
  output logic             Hit,
  output logic             Busy
);

  localparam int unsigned Depth = 2 ** IDX_W;

  typedef enum logic {StIdle, StSweep} state_e;

  state_e           state_q, state_d;
  logic [IDX_W:0]   sweep_idx_q, sweep_idx_d;
  logic [Depth-1:0] valid_q, valid_d;
  logic [PC_W-1:0]  tgt_mem [Depth];
  logic [Depth-1:0] rel_mem;
  logic [PC_W-1:0]  target_q, target_d;
  logic             hit_q, hit_d;
  logic             tv_q, tv_d;

  logic             load_fire;
  logic             fwd;
  logic             ent_valid;
  logic             ent_rel;
  logic [PC_W-1:0]  ent_tgt;

  // Reset gates the load so a write in flight during reset is dropped.
  assign LoadReady = (state_q == StIdle) & ~Clear & Reset;
  assign load_fire = LoadValid & LoadReady;
  assign Busy      = (state_q == StSweep) | ~Reset;

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    valid_d     = valid_q;
    unique case (state_q)
      StIdle: begin
        if (Clear) begin
          state_d     = StSweep;
          sweep_idx_d = '0;
        end
      end
      StSweep: begin
        valid_d[sweep_idx_q[IDX_W-1:0]] = 1'b0;
        if (Clear) begin
          sweep_idx_d = '0;
        end else if (sweep_idx_q == (IDX_W+1)'(Depth - 1)) begin
          state_d     = StIdle;
          sweep_idx_d = '0;
        end else begin
          sweep_idx_d = sweep_idx_q + (IDX_W+1)'(1);
        end
      end
      default: begin
        state_d     = StSweep;
        sweep_idx_d = '0;
      end
    endcase
    if (load_fire) begin
      valid_d[LoadIdx] = 1'b1;
    end
  end

  // Same-cycle load to the looked-up index is forwarded to the lookup.
  always_comb begin
    fwd       = load_fire && (LoadIdx == Addr);
    ent_valid = fwd | valid_q[Addr];
    ent_rel   = fwd ? LoadRel : rel_mem[Addr];
    ent_tgt   = fwd ? LoadTarget : tgt_mem[Addr];
    target_d  = target_q;
    hit_d     = hit_q;
    tv_d      = LookupEn;
    if (LookupEn) begin
      if ((state_q == StIdle) && ent_valid) begin
        hit_d    = 1'b1;
        target_d = ent_rel ? (PC + ent_tgt) : ent_tgt;
      end else begin
        hit_d    = 1'b0;
        target_d = PC_W'(DEFAULT_TGT);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= StSweep;
      sweep_idx_q <= '0;
      target_q    <= '0;
      hit_q       <= 1'b0;
      tv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      valid_q     <= valid_d;
      target_q    <= target_d;
      hit_q       <= hit_d;
      tv_q        <= tv_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (load_fire) begin
      tgt_mem[LoadIdx] <= LoadTarget;
      rel_mem[LoadIdx] <= LoadRel;
    end
  end

  assign Target      = target_q;
  assign Hit         = hit_q;
  assign TargetValid = tv_q;

endmodule

// File: tb/tb_jump_target_table.sv
// Directed bench for jump_target_table: expected lookups are queued at issue time and a
// monitor pops and compares them whenever TargetValid is seen.
module tb_jump_target_table;

  logic       clk;
  logic       reset_n;
  logic       clear;
  logic       load_valid;
  logic       load_ready;
  logic [4:0] load_idx;
  logic [9:0] load_target;
  logic       load_rel;
  logic       lookup_en;
  logic [4:0] addr;
  logic [9:0] pc;
  logic [9:0] target;
  logic       target_valid;
  logic       hit;
  logic       busy;

  int checks;
  int errors;
  logic [10:0] exp_q[$];

  jump_target_table #(
    .PC_W       (10),
    .IDX_W      (5),
    .DEFAULT_TGT(1)
  ) dut (
    .Clk        (clk),
    .Reset      (reset_n),
    .Clear      (clear),
    .LoadValid  (load_valid),
    .LoadReady  (load_ready),
    .LoadIdx    (load_idx),
    .LoadTarget (load_target),
    .LoadRel    (load_rel),
    .LookupEn   (lookup_en),
    .Addr       (addr),
    .PC         (pc),
    .Target     (target),
    .TargetValid(target_valid),
    .Hit        (hit),
    .Busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (target_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_lookup: got hit=%0b target=%0h expected none", hit, target);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        check("lookup {hit,target}", {21'd0, hit, target}, {21'd0, e});
      end
    end
  end

  task automatic load(input logic [4:0] idx, input logic [9:0] tgt, input logic rel);
    load_valid  = 1'b1;
    load_idx    = idx;
    load_target = tgt;
    load_rel    = rel;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  task automatic lookup(input logic [4:0] a, input logic [9:0] p, input logic [9:0] et,
                        input logic eh);
    addr      = a;
    pc        = p;
    lookup_en = 1'b1;
    exp_q.push_back({eh, et});
    @(posedge clk);
    #1;
    lookup_en = 1'b0;
    @(negedge clk);
    check("lookup_latency", {31'd0, target_valid}, 32'd1);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
  endtask

  initial begin
    int n;
    int lr_bad;
    checks      = 0;
    errors      = 0;
    reset_n     = 1'b0;
    clear       = 1'b0;
    load_valid  = 1'b0;
    load_idx    = '0;
    load_target = '0;
    load_rel    = 1'b0;
    lookup_en   = 1'b0;
    addr        = '0;
    pc          = '0;

    // Reset sweep
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_target", {22'd0, target}, 32'd0);
    check("reset_hit", {31'd0, hit}, 32'd0);
    check("reset_tv", {31'd0, target_valid}, 32'd0);
    check("reset_load_ready", {31'd0, load_ready}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    lookup_en = 1'b1;
    addr      = 5'd6;
    n         = 0;
    lr_bad    = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (load_ready) lr_bad++;
      exp_q.push_back({1'b0, 10'h001});
    end
    lookup_en = 1'b0;
    check("reset_sweep_len", n, 32'd32);
    check("sweep_load_ready_low", lr_bad, 32'd0);

    // Absolute entries
    load(5'd6, 10'h021, 1'b0);
    load(5'd7, 10'h06C, 1'b0);
    load(5'd8, 10'h098, 1'b0);
    load(5'd5, 10'h0B0, 1'b0);
    lookup(5'd6, 10'h000, 10'h021, 1'b1);
    lookup(5'd7, 10'h000, 10'h06C, 1'b1);
    lookup(5'd8, 10'h000, 10'h098, 1'b1);
    lookup(5'd5, 10'h000, 10'h0B0, 1'b1);
    lookup(5'd9, 10'h000, 10'h001, 1'b0);

    // Relative entry, including wrap-around
    load(5'd0, 10'h3F0, 1'b1);
    lookup(5'd0, 10'h040, 10'h030, 1'b1);
    lookup(5'd0, 10'h005, 10'h3F5, 1'b1);

    // Forwarding: same-cycle load and lookup
    load_valid  = 1'b1;
    load_idx    = 5'd3;
    load_target = 10'h123;
    load_rel    = 1'b0;
    lookup(5'd3, 10'h000, 10'h123, 1'b1);
    load_valid  = 1'b1;
    load_idx    = 5'd3;
    lookup(5'd4, 10'h000, 10'h001, 1'b0);
    load_valid  = 1'b0;

    // Clear wins over a same-cycle load
    load(5'd2, 10'h055, 1'b0);
    lookup(5'd2, 10'h000, 10'h055, 1'b1);
    clear       = 1'b1;
    load_valid  = 1'b1;
    load_idx    = 5'd2;
    load_target = 10'h0AA;
    load_rel    = 1'b0;
    @(negedge clk);
    check("clear_load_ready", {31'd0, load_ready}, 32'd0);
    @(posedge clk);
    #1;
    clear      = 1'b0;
    load_valid = 1'b0;
    count_busy(n);
    check("clear_sweep_len", n, 32'd32);
    lookup(5'd2, 10'h000, 10'h001, 1'b0);
    lookup(5'd6, 10'h000, 10'h001, 1'b0);
    lookup(5'd3, 10'h000, 10'h001, 1'b0);
    lookup(5'd0, 10'h040, 10'h001, 1'b0);
    load(5'd6, 10'h2AB, 1'b0);
    lookup(5'd6, 10'h000, 10'h2AB, 1'b1);

    // Reset mid-sweep, with a load and lookup presented during reset
    @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset_n     = 1'b0;
    load_valid  = 1'b1;
    load_idx    = 5'd9;
    load_target = 10'h1C1;
    lookup_en   = 1'b1;
    addr        = 5'd6;
    @(posedge clk);
    #1;
    check("midreset_target", {22'd0, target}, 32'd0);
    check("midreset_hit", {31'd0, hit}, 32'd0);
    check("midreset_tv", {31'd0, target_valid}, 32'd0);
    check("midreset_load_ready", {31'd0, load_ready}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd1);
    reset_n    = 1'b1;
    load_valid = 1'b0;
    lookup_en  = 1'b0;
    count_busy(n);
    check("midreset_sweep_len", n, 32'd32);
    lookup(5'd9, 10'h000, 10'h001, 1'b0);
    lookup(5'd6, 10'h000, 10'h001, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
